// File: rtl/fbuf_pkg.sv
// Shared definitions for the frame-buffer transpose sequencer.
package fbuf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2
  } state_t;

  localparam logic MODE_RASTER    = 1'b0;
  localparam logic MODE_TRANSPOSE = 1'b1;

  localparam int PIX_W_DEF = 8;

endpackage

// File: rtl/fbuf_transpose_ctrl_if.sv
// Pixel-in, RAM-port and pixel-out signals of the frame-buffer sequencer.
interface fbuf_transpose_ctrl_if
  import fbuf_pkg::*;
#(
  parameter int IMG_DIM = 512,
  parameter int PIX_W   = PIX_W_DEF
);
  localparam int AW = $clog2(IMG_DIM);

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             wr_en;
  logic [AW-1:0]    wr_bank;
  logic [AW-1:0]    wr_addr;
  logic [PIX_W-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_bank;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_sof;
  logic             out_eol;

  modport master (
    input  in_valid, in_sof, in_pixel, rd_data, out_ready,
    output wr_en, wr_bank, wr_addr, wr_data,
    output rd_en, rd_bank, rd_addr,
    output out_valid, out_pixel, out_sof, out_eol
  );

  modport slave (
    output in_valid, in_sof, in_pixel, rd_data, out_ready,
    input  wr_en, wr_bank, wr_addr, wr_data,
    input  rd_en, rd_bank, rd_addr,
    input  out_valid, out_pixel, out_sof, out_eol
  );

endinterface

// File: rtl/fbuf_skid2.sv
// Two-entry FIFO holding read-back pixels with their frame markers; count drives read credit.
module fbuf_skid2 #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wp;
  logic          rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/fbuf_transpose_ctrl.sv
// Frame-buffer sequencer: captures one frame into row-banked RAM, then streams it
// out in raster or transposed order through a credit-limited 2-entry skid buffer.
//   state   | meaning
//   IDLE    | waiting for a valid start-of-frame pixel
//   CAPTURE | writing pixels, bank = row, addr = column
//   READOUT | issuing reads and draining the skid buffer to the consumer
module fbuf_transpose_ctrl
  import fbuf_pkg::*;
#(
  parameter int IMG_DIM = 512,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int AW      = $clog2(IMG_DIM)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_operation,
  fbuf_transpose_ctrl_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic err_restart
);

  localparam logic [AW-1:0] LAST = AW'(IMG_DIM - 1);

  state_t           state;
  logic             mode;
  logic [AW-1:0]    x;
  logic [AW-1:0]    y;
  logic             rd_done;
  logic             inflight;
  logic             inflight_sof;
  logic             inflight_eol;
  logic [1:0]       occ;
  logic [PIX_W+1:0] head;
  logic             in_readout;
  logic             pop;
  logic             issue;

  assign in_readout = (state == READOUT);
  assign busy       = (state != IDLE);
  assign pop        = bus.out_valid && bus.out_ready;
  // A pop this cycle frees its slot before the new read can land, keeping 1 pixel/cycle.
  assign issue      = in_readout && !rd_done &&
                      (({1'b0, occ} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);

  assign bus.rd_en   = issue;
  assign bus.rd_bank = in_readout ? ((mode == MODE_TRANSPOSE) ? x : y) : '0;
  assign bus.rd_addr = in_readout ? ((mode == MODE_TRANSPOSE) ? y : x) : '0;

  fbuf_skid2 #(.DW(PIX_W + 2)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   ({inflight_sof, inflight_eol, bus.rd_data}),
    .pop   (pop),
    .dout  (head),
    .count (occ)
  );

  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_pixel = head[PIX_W-1:0];
  assign bus.out_sof   = bus.out_valid && head[PIX_W+1];
  assign bus.out_eol   = bus.out_valid && head[PIX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode         <= MODE_RASTER;
      x            <= '0;
      y            <= '0;
      rd_done      <= 1'b0;
      inflight     <= 1'b0;
      inflight_sof <= 1'b0;
      inflight_eol <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_bank  <= '0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      frame_done   <= 1'b0;
      err_restart  <= 1'b0;
    end else begin
      bus.wr_en    <= 1'b0;
      frame_done   <= 1'b0;
      err_restart  <= 1'b0;
      inflight     <= issue;
      inflight_sof <= issue && (x == '0) && (y == '0);
      inflight_eol <= issue && (x == LAST);
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_sof) begin
            bus.wr_en   <= 1'b1;
            bus.wr_bank <= '0;
            bus.wr_addr <= '0;
            bus.wr_data <= bus.in_pixel;
            x           <= AW'(1);
            y           <= '0;
            mode        <= sel_operation;
            rd_done     <= 1'b0;
            state       <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.in_valid) begin
            bus.wr_en   <= 1'b1;
            bus.wr_data <= bus.in_pixel;
            if (bus.in_sof && ((x != '0) || (y != '0))) begin
              err_restart <= 1'b1;
              bus.wr_bank <= '0;
              bus.wr_addr <= '0;
              x           <= AW'(1);
              y           <= '0;
              mode        <= sel_operation;
            end else begin
              bus.wr_bank <= y;
              bus.wr_addr <= x;
              x           <= x + AW'(1);
              if (x == LAST) begin
                y <= y + AW'(1);
                if (y == LAST) state <= READOUT;
              end
            end
          end
        end
        READOUT: begin
          if (issue) begin
            x <= x + AW'(1);
            if (x == LAST) begin
              y <= y + AW'(1);
              if (y == LAST) rd_done <= 1'b1;
            end
          end
          // Last pixel leaves when everything is issued and it is the only one left.
          if (pop && rd_done && !inflight && (occ == 2'd1)) frame_done <= 1'b1;
          if (frame_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fbuf_transpose_ctrl.sv
// Directed bench for fbuf_transpose_ctrl at IMG_DIM = 4: table of frame vectors plus
// restart and mid-readout reset sequences.
module tb_fbuf_transpose_ctrl;
  import fbuf_pkg::*;

  localparam int DIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_operation = 1'b0;
  logic busy, frame_done, err_restart;

  fbuf_transpose_ctrl_if #(.IMG_DIM(DIM), .PIX_W(8)) bus ();

  fbuf_transpose_ctrl #(.IMG_DIM(DIM), .PIX_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_operation (sel_operation),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_restart   (err_restart)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [DIM*DIM];
  always @(posedge clk) begin
    if (bus.wr_en) ram[{bus.wr_bank, bus.wr_addr}] <= bus.wr_data;
    if (bus.rd_en) bus.rd_data <= ram[{bus.rd_bank, bus.rd_addr}];
  end

  typedef struct {
    logic         mode;
    int           gap;
    logic         bp;
    logic [127:0] pix;
    logic [15:0]  sof_m;
    logic [15:0]  eol_m;
  } vec_t;

  vec_t vecs [4];

  int checks = 0;
  int errors = 0;
  int done_cnt, err_cnt, issued, accepted, cred_viol, cyc;
  logic fd_prev = 1'b0;
  logic busy_at_fd, busy_after_fd, bp_en;
  logic [9:0]  got [$];
  logic [11:0] wr_log [$];

  always @(negedge clk) begin
    if (fd_prev) busy_after_fd = busy;
    if (frame_done) begin
      done_cnt++;
      busy_at_fd = busy;
    end
    fd_prev = frame_done;
    if (err_restart) err_cnt++;
    if (bus.wr_en) wr_log.push_back({bus.wr_bank, bus.wr_addr, bus.wr_data});
    if (bus.rd_en) issued++;
    if (bus.out_valid && bus.out_ready) begin
      accepted++;
      got.push_back({bus.out_sof, bus.out_eol, bus.out_pixel});
    end
    if (issued - accepted > 2) cred_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {bus.wr_en, bus.rd_en, bus.out_valid, bus.out_sof, bus.out_eol, busy, frame_done,
            err_restart, bus.wr_bank, bus.wr_addr, bus.rd_bank, bus.rd_addr, bus.wr_data,
            bus.out_pixel};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.out_ready = bp_en ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic clear_logs();
    got.delete();
    wr_log.delete();
    done_cnt = 0;
    err_cnt = 0;
    issued = 0;
    accepted = 0;
    cred_viol = 0;
    busy_at_fd = 1'b0;
    busy_after_fd = 1'b1;
  endtask

  task automatic send_pix(input logic [7:0] p, input logic sof, input int gap);
    bus.in_valid = 1'b1;
    bus.in_sof = sof;
    bus.in_pixel = p;
    tick();
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    for (int g = 1; g < gap; g++) tick();
  endtask

  task automatic send_frame(input logic mode, input int gap);
    sel_operation = mode;
    for (int k = 0; k < 16; k++) send_pix(8'(k), k == 0, gap);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) tick();
  endtask

  task automatic check_out(input int v, input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_pix%0d", tag, i), 32'((i < got.size()) ? got[i] : 10'h3ff),
            32'({vecs[v].sof_m[i], vecs[v].eol_m[i], vecs[v].pix[i*8 +: 8]}));
    check({tag, "_frame_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_credit"}, 32'(cred_viol), 32'd0);
  endtask

  task automatic check_wr(input int base, input string tag);
    check({tag, "_wr_count"}, 32'(wr_log.size()), 32'(base + 16));
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_wr%0d", tag, k),
            32'((base + k < wr_log.size()) ? wr_log[base + k] : 12'hfff), 32'(k * 257));
  endtask

  task automatic run_vec(input int v);
    string tag;
    tag = $sformatf("vec%0d", v);
    clear_logs();
    bp_en = vecs[v].bp;
    send_frame(vecs[v].mode, vecs[v].gap);
    wait_done(tag);
    bp_en = 1'b0;
    check_out(v, tag);
    check_wr(0, tag);
    check({tag, "_err_restart"}, 32'(err_cnt), 32'd0);
    check({tag, "_busy_at_done"}, 32'(busy_at_fd), 32'd1);
    check({tag, "_busy_after_done"}, 32'(busy_after_fd), 32'd0);
  endtask

  initial begin
    vecs[0] = '{mode: MODE_RASTER, gap: 1, bp: 1'b0,
                pix: 128'h0f0e0d0c0b0a09080706050403020100, sof_m: 16'h0001, eol_m: 16'h8888};
    vecs[1] = '{mode: MODE_TRANSPOSE, gap: 1, bp: 1'b0,
                pix: 128'h0f0b07030e0a06020d0905010c080400, sof_m: 16'h0001, eol_m: 16'h8888};
    vecs[2] = '{mode: MODE_TRANSPOSE, gap: 1, bp: 1'b1,
                pix: 128'h0f0b07030e0a06020d0905010c080400, sof_m: 16'h0001, eol_m: 16'h8888};
    vecs[3] = '{mode: MODE_RASTER, gap: 3, bp: 1'b0,
                pix: 128'h0f0e0d0c0b0a09080706050403020100, sof_m: 16'h0001, eol_m: 16'h8888};

    cyc = 0;
    bp_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_pixel = 8'h00;
    bus.out_ready = 1'b1;
    clear_logs();
    repeat (3) tick();
    check("reset_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_outputs", out_vec(), 32'd0);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Restart mid-capture: partial transposed frame, then a full raster frame.
    clear_logs();
    sel_operation = MODE_TRANSPOSE;
    for (int k = 0; k < 7; k++) send_pix(8'(8'hc0 + k), k == 0, 1);
    send_frame(MODE_RASTER, 1);
    wait_done("restart");
    check_out(0, "restart");
    check_wr(7, "restart");
    check("restart_err_cnt", 32'(err_cnt), 32'd1);

    // Reset in the middle of readout, then a clean transposed frame.
    clear_logs();
    send_frame(MODE_RASTER, 1);
    begin
      int n = 0;
      while (accepted < 5 && n < 100) begin
        tick();
        n++;
      end
    end
    check("midrst_reached_5", 32'(accepted >= 5), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", out_vec(), 32'd0);
    repeat (2) tick();
    check("midrst_held_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    tick();
    run_vec(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
